// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage: FSM encoding,
// halfword/instruction widths and the RVC length decode.
package fetch_pkg;

    localparam int HW_W = 16;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    // Any halfword whose two low bits are not 2'b11 starts a 16-bit instruction.
    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch stage's external handshakes: the instruction cache
// request port, the execute-stage redirect, and the decode output stream.
interface instruction_fetch_unit_if;

    logic                       inst_cache_enable;
    logic [63:0]                inst_cache_addr;
    logic [63:0]                inst_cache_data;
    logic                       inst_cache_busy;

    logic                       redirect_valid;
    logic [63:0]                redirect_pc;

    // Decode stream: a transfer happens in any cycle with dec_valid && dec_ready
    // (and no redirect); dec_valid never looks at dec_ready, and the payload stays
    // stable until it is accepted or a redirect flushes it.
    logic                       dec_valid;
    logic                       dec_ready;
    logic [fetch_pkg::ILEN-1:0] dec_inst;
    logic [63:0]                dec_pc;
    logic                       dec_compressed;

    modport master (
        output inst_cache_enable, inst_cache_addr,
        input  inst_cache_data, inst_cache_busy,
        input  redirect_valid, redirect_pc,
        output dec_valid, dec_inst, dec_pc, dec_compressed,
        input  dec_ready
    );

    modport slave (
        input  inst_cache_enable, inst_cache_addr,
        output inst_cache_data, inst_cache_busy,
        output redirect_valid, redirect_pc,
        input  dec_valid, dec_inst, dec_pc, dec_compressed,
        output dec_ready
    );

endinterface

// File: rtl/halfword_queue.sv
// Circular halfword buffer between the cache and decode: two halfwords in per
// fetch, one or two out per decoded instruction, single-cycle flush.
module halfword_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [2*HW_W-1:0]        push_data_i,
    input  logic                     pop_one_i,
    input  logic                     pop_two_i,
    output logic [HW_W-1:0]          head0_o,
    output logic [HW_W-1:0]          head1_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [HW_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   pop_n;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_n    = pop_one_i ? CW'(1) : (pop_two_i ? CW'(2) : CW'(0));
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PW'(2);
            end
            rd_ptr_d = rd_ptr_q + PW'(pop_n);
            count_d  = count_q + (push_i ? CW'(2) : CW'(0)) - pop_n;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they exist.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q]          <= push_data_i[HW_W-1:0];
            mem_q[wr_ptr_q + PW'(1)] <= push_data_i[2*HW_W-1:HW_W];
        end
    end

    assign head0_o = mem_q[rd_ptr_q];
    assign head1_o = mem_q[rd_ptr_q + PW'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: walks the PC through the instruction cache one 32-bit word at a
// time and hands whole RV64IC instructions to decode, honouring execute redirects.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          HW_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    instruction_fetch_unit_if.master bus,
    output fetch_state_e            state_dbg_o
);

    localparam int CW = $clog2(HW_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [63:0]     head_pc_q, head_pc_d;
    logic [CW-1:0]   hw_count;
    logic [HW_W-1:0] head0, head1;
    logic            head_comp;
    logic            has_room;
    logic            dec_valid;
    logic            dec_fire;
    logic            push;
    logic            unused_bits;

    halfword_queue #(.DEPTH(HW_DEPTH)) u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush_i    (bus.redirect_valid),
        .push_i     (push),
        .push_data_i(bus.inst_cache_data[2*HW_W-1:0]),
        .pop_one_i  (dec_fire & head_comp),
        .pop_two_i  (dec_fire & ~head_comp),
        .head0_o    (head0),
        .head1_o    (head1),
        .count_o    (hw_count)
    );

    // Room is judged on registered occupancy, so an in-flight word always fits.
    assign has_room  = (CW'(HW_DEPTH) - hw_count) >= CW'(2);
    assign head_comp = is_compressed(head0);
    assign dec_valid = (hw_count != '0) && (head_comp || (hw_count >= CW'(2)));
    assign dec_fire  = dec_valid & bus.dec_ready & ~bus.redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE:    if (has_room) state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT: begin
                if (!bus.inst_cache_busy) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    state_d    = IDLE;
                end
            end
            DISCARD: if (!bus.inst_cache_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A redirect overrides everything: any cache word in flight is stale.
        if (bus.redirect_valid) begin
            push       = 1'b0;
            fetch_pc_d = {bus.redirect_pc[63:1], 1'b0};
            state_d    = (state_q == IDLE) ? REQ : DISCARD;
        end
    end

    always_comb begin
        head_pc_d = head_pc_q;
        if (bus.redirect_valid) begin
            head_pc_d = {bus.redirect_pc[63:1], 1'b0};
        end else if (dec_fire) begin
            head_pc_d = head_pc_q + (head_comp ? 64'd2 : 64'd4);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
        end
    end

    // Enable drops in the completion cycle so the cache never sees a second request.
    assign bus.inst_cache_enable = (state_q == REQ) | ((state_q == WAIT) & bus.inst_cache_busy);
    assign bus.inst_cache_addr   = fetch_pc_q;

    assign bus.dec_valid      = dec_valid;
    assign bus.dec_pc         = head_pc_q;
    assign bus.dec_compressed = dec_valid & head_comp;
    assign bus.dec_inst       = !dec_valid ? '0 :
                                head_comp  ? {{(ILEN-HW_W){1'b0}}, head0} : {head1, head0};

    assign state_dbg_o = state_q;
    assign unused_bits = ^{bus.inst_cache_data[63:2*HW_W], bus.redirect_pc[0]};

endmodule
